alu_lockstep_stim: RTL and testbench
====================================

// Module: alu_lockstep_stim
// PURPOSE
//   Self-checking stimulus generator for the dual-ALU lockstep comparator (alu_xor_4).
//   Drives identical pseudo-random operand/select vectors into both ALU channels.
//   After a fixed compare latency, samples the comparator's mismatch outputs (x, y) and counts errors.
//   Sits beside alu_xor_4 inside the user project wrapper; the io_in pads remain an alternative source.
// PARAMETERS
//   LFSR_SEED    16'hACE1  LFSR value reloaded on every accepted start
//   CMP_LATENCY  1         cycles from operand drive to valid x_i/y_i (range 1..15)
//   ERR_W        8         error counter width; counter saturates at all-ones
// PORTS
//   wb_clk_i          in   1      single clock
//   wb_rst_n_i        in   1      asynchronous reset, active-low
//   start_i           in   1      run request; accepted only in IDLE or DONE
//   inject_i          in   1      sampled with start; forces a fault on vector 0
//   num_vec_i         in   16     vectors per run; latched at start
//   a0_o,b0_o         out  4      channel-1 operands
//   a1_o,b1_o         out  4      channel-2 operands
//   sel1_o,sel2_o     out  2      channel-1/2 ALU selects
//   x_i               in   4      comparator result mismatch bits
//   y_i               in   1      comparator carry mismatch bit
//   busy_o            out  1      high from accepted start until DONE
//   done_o            out  1      level; high in DONE until next accepted start
//   err_cnt_o         out  ERR_W  mismatching vectors in this run (saturating)
//   first_err_vld_o   out  1      at least one mismatch seen in this run
//   first_err_idx_o   out  16     index of the first mismatching vector
// BEHAVIOUR
//   - Reset: every output 0; FSM in IDLE; LFSR = LFSR_SEED. Reset mid-run aborts immediately, no partial results.
//   - FSM states: IDLE -> DRIVE -> WAIT -> CHECK -> (DRIVE | DONE); DONE -> DRIVE on start.
//   - start accepted in IDLE/DONE:
//       - clear err_cnt, first_err_vld, first_err_idx; vec_idx = 0.
//       - latch num_vec_i and inject_i; reload LFSR_SEED.
//       - busy_o=1 and done_o=0 the next cycle.
//   - start while busy: ignored, with no effect on the run.
//   - num_vec_i == 0 at start: go straight to DONE the next cycle, err_cnt_o = 0.
//   - DRIVE (1 cycle): operand outputs are registered and update on entry, from lfsr:
//       - a0=a1=lfsr[3:0]; b0=b1=lfsr[7:4]; sel1=sel2=lfsr[9:8].
//       - Injection (vec_idx==0 and inject latched): a1 = ~lfsr[3:0] instead.
//       - Operands hold their value until the next DRIVE.
//   - WAIT: exactly CMP_LATENCY cycles, counted by a 4-bit down-counter.
//   - CHECK (1 cycle):
//       - mismatch = (|x_i) | y_i.
//       - On mismatch: err_cnt++ (saturates at 2^ERR_W-1).
//       - On mismatch with first_err_vld==0: set first_err_vld, first_err_idx = vec_idx.
//       - Then if vec_idx == latched_num-1 -> DONE; else vec_idx++, LFSR steps, -> DRIVE.
//   - LFSR: 16-bit Galois, lfsr_next = {1'b0,lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0). Steps only in CHECK.
//   - Run length: num_vec*(CMP_LATENCY+2) cycles from first DRIVE to DONE entry.
//   - DONE: busy_o=0, done_o=1; results and operands hold until the next accepted start.
// STRUCTURE
//   - Package alu_stim_pkg holds:
//       - state encoding (IDLE/DRIVE/WAIT/CHECK/DONE);
//       - LFSR_TAPS = 16'hB400;
//       - operand/select field positions.
//   - Sub-module lfsr16_galois (seed load, step enable, parallel output); the rest is inline FSM plus counters.
// TESTING (bench stub ALU: x = a0^a1 | {4{sel1!=sel2}}, y = b0!=b1, valid CMP_LATENCY cycles after drive)
//   1 Reset asserted mid-run -> all outputs 0 within the same cycle; after release, start runs cleanly.
//   2 num_vec=2, no inject -> two drives: (a=1,b=E,sel=00), then (a=0,b=7,sel=10);
//     done_o after 6 cycles; err_cnt_o=0; first_err_vld_o=0.
//   3 num_vec=4, inject=1 -> a1_o=4'hE on vector 0; err_cnt_o=1; first_err_idx_o=0.
//   4 num_vec=0 -> done_o=1 one cycle after start; err_cnt_o=0; no operand change.
//   5 Stub forces y=1, num_vec=300, ERR_W=8 -> err_cnt_o=255 (saturated); first_err_idx_o=0.
//   6 start pulsed during WAIT -> ignored; the run completes with the original num_vec; restart from DONE reproduces the identical vector sequence.

Source files
------------

// File: rtl/alu_lockstep_stim_pkg.sv
// Shared constants for the lockstep ALU stimulus generator: FSM encoding,
// LFSR taps and the operand/select field positions inside the LFSR word.
package alu_stim_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DRIVE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Field positions of one vector inside the LFSR value.
  localparam int A_LSB   = 0;
  localparam int B_LSB   = 4;
  localparam int SEL_LSB = 8;
  localparam int FIELD_W = 10;

  typedef struct packed {
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [1:0] sel1;
    logic [1:0] sel2;
  } operands_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/alu_lockstep_stim_if.sv
// Operand/result bus between the stimulus generator (master) and the
// dual-ALU lockstep comparator (slave).
interface alu_lockstep_stim_if;
  logic [3:0] a0_o;
  logic [3:0] b0_o;
  logic [3:0] a1_o;
  logic [3:0] b1_o;
  logic [1:0] sel1_o;
  logic [1:0] sel2_o;
  logic [3:0] x_i;
  logic       y_i;

  modport master (output a0_o, b0_o, a1_o, b1_o, sel1_o, sel2_o, input x_i, y_i);
  modport slave  (input a0_o, b0_o, a1_o, b1_o, sel1_o, sel2_o, output x_i, y_i);
endinterface

// File: rtl/alu_lockstep_stim_lfsr.sv
// 16-bit Galois LFSR with seed reload and step enable. Besides the state it
// offers the low bits of the next value so the caller can register operands
// on the same edge the LFSR advances.
module lfsr16_galois
  import alu_stim_pkg::*;
#(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          PEEK_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              step_i,
  output logic [15:0]       q_o,
  output logic [PEEK_W-1:0] next_lo_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Load has priority over step; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = SEED;
    else if (step_i) lfsr_d = lfsr_step(lfsr_q);
  end

  // LFSR state register, seeded on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  logic [15:0] step_val;
  assign step_val  = lfsr_step(lfsr_q);
  assign next_lo_o = step_val[PEEK_W-1:0];
  assign q_o       = lfsr_q;

endmodule

// File: rtl/alu_lockstep_stim.sv
// Stimulus generator for the dual-ALU lockstep comparator: drives identical
// pseudo-random vectors into both channels, waits the compare latency,
// samples the mismatch bits and accumulates per-run error statistics.
//
// Handshake: start_i is a level sampled every clock; it is accepted only in
// IDLE or DONE (no ready signal), and is silently ignored while busy_o=1.
// A run ends with done_o held high until the next accepted start.
module alu_lockstep_stim
  import alu_stim_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          CMP_LATENCY = 1,
  parameter int          ERR_W       = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 start_i,
  input  logic                 inject_i,
  input  logic [15:0]          num_vec_i,
  alu_lockstep_stim_if.master  alu,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ERR_W-1:0]     err_cnt_o,
  output logic                 first_err_vld_o,
  output logic [15:0]          first_err_idx_o,
  output logic [2:0]           state_o,
  output logic [15:0]          lfsr_o
);

  logic [2:0]       state_q, state_d;
  logic [15:0]      vec_idx_q, num_q;
  logic [3:0]       wait_q;
  logic [ERR_W-1:0] err_q;
  logic             vld_q;
  logic [15:0]      idx_q;
  operands_t        ops_q;

  logic               start_acc, mismatch, last_vec, step_en;
  logic [FIELD_W-1:0] next_lo;

  assign start_acc = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign mismatch  = (|alu.x_i) | alu.y_i;
  assign last_vec  = (vec_idx_q == num_q - 16'd1);
  assign step_en   = (state_q == S_CHECK) && !last_vec;

  lfsr16_galois #(.SEED(LFSR_SEED), .PEEK_W(FIELD_W)) u_lfsr (
    .clk_i     (wb_clk_i),
    .rst_n_i   (wb_rst_n_i),
    .load_i    (start_acc),
    .step_i    (step_en),
    .q_o       (lfsr_o),
    .next_lo_o (next_lo)
  );

  // Next-state logic of the run sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_acc) state_d = (num_vec_i == 16'd0) ? S_DONE : S_DRIVE;
      S_DRIVE:        state_d = S_WAIT;
      S_WAIT:         if (wait_q == 4'd0) state_d = S_CHECK;
      S_CHECK:        state_d = last_vec ? S_DONE : S_DRIVE;
      default:        state_d = S_IDLE;
    endcase
  end

  // State, run bookkeeping and compare-latency down-counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q   <= S_IDLE;
      vec_idx_q <= '0;
      num_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        vec_idx_q <= '0;
        num_q     <= num_vec_i;
      end else if (step_en) begin
        vec_idx_q <= vec_idx_q + 16'd1;
      end
      if (state_q == S_DRIVE)                    wait_q <= 4'(CMP_LATENCY - 1);
      else if (state_q == S_WAIT && wait_q != 0) wait_q <= wait_q - 4'd1;
    end
  end

  // Error statistics: cleared on start, updated in CHECK, counter saturates.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      err_q <= '0;
      vld_q <= 1'b0;
      idx_q <= '0;
    end else if (start_acc) begin
      err_q <= '0;
      vld_q <= 1'b0;
      idx_q <= '0;
    end else if (state_q == S_CHECK && mismatch) begin
      if (err_q != {ERR_W{1'b1}}) err_q <= err_q + 1'b1;
      if (!vld_q) begin
        vld_q <= 1'b1;
        idx_q <= vec_idx_q;
      end
    end
  end

  // Operands register on DRIVE entry: vector 0 comes straight from the seed
  // (the LFSR is reloaded on the same edge), later vectors from the stepped
  // value. inject_i is only consumed on the start edge, where vector 0 loads.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ops_q <= '0;
    end else if (start_acc && num_vec_i != 16'd0) begin
      ops_q.a0   <= LFSR_SEED[A_LSB +: 4];
      ops_q.a1   <= inject_i ? ~LFSR_SEED[A_LSB +: 4] : LFSR_SEED[A_LSB +: 4];
      ops_q.b0   <= LFSR_SEED[B_LSB +: 4];
      ops_q.b1   <= LFSR_SEED[B_LSB +: 4];
      ops_q.sel1 <= LFSR_SEED[SEL_LSB +: 2];
      ops_q.sel2 <= LFSR_SEED[SEL_LSB +: 2];
    end else if (step_en) begin
      ops_q.a0   <= next_lo[A_LSB +: 4];
      ops_q.a1   <= next_lo[A_LSB +: 4];
      ops_q.b0   <= next_lo[B_LSB +: 4];
      ops_q.b1   <= next_lo[B_LSB +: 4];
      ops_q.sel1 <= next_lo[SEL_LSB +: 2];
      ops_q.sel2 <= next_lo[SEL_LSB +: 2];
    end
  end

  assign alu.a0_o   = ops_q.a0;
  assign alu.b0_o   = ops_q.b0;
  assign alu.a1_o   = ops_q.a1;
  assign alu.b1_o   = ops_q.b1;
  assign alu.sel1_o = ops_q.sel1;
  assign alu.sel2_o = ops_q.sel2;

  assign busy_o          = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done_o          = (state_q == S_DONE);
  assign err_cnt_o       = err_q;
  assign first_err_vld_o = vld_q;
  assign first_err_idx_o = idx_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_alu_lockstep_stim.sv
// Bench for alu_lockstep_stim: a stub lockstep comparator, a table of runs
// with expected statistics, an operand scoreboard fed from an LFSR model,
// and hand-written sequences for reset abort and start-while-busy.
module tb_alu_lockstep_stim;
  import alu_stim_pkg::*;

  localparam int          L     = 1;
  localparam int          ERR_W = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_i = 1'b0, inject_i = 1'b0;
  logic [15:0]      num_vec_i = '0;
  logic             busy_o, done_o, first_err_vld_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [15:0]      first_err_idx_o, lfsr_o;
  logic [2:0]       state_o;
  logic             force_y = 1'b0;

  alu_lockstep_stim_if bus();

  alu_lockstep_stim #(.LFSR_SEED(SEED), .CMP_LATENCY(L), .ERR_W(ERR_W)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start_i(start_i), .inject_i(inject_i),
    .num_vec_i(num_vec_i), .alu(bus.master), .busy_o(busy_o), .done_o(done_o),
    .err_cnt_o(err_cnt_o), .first_err_vld_o(first_err_vld_o),
    .first_err_idx_o(first_err_idx_o), .state_o(state_o), .lfsr_o(lfsr_o)
  );

  // ---------------- stub comparator, L-cycle pipeline ----------------
  logic [4:0] pipe [L];
  logic [4:0] stub_comb;
  assign stub_comb = {(bus.a0_o ^ bus.a1_o) | {4{bus.sel1_o != bus.sel2_o}},
                      (bus.b0_o != bus.b1_o) | force_y};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < L; i++) pipe[i] <= '0;
    else begin
      pipe[0] <= stub_comb;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign bus.x_i = pipe[L-1][4:1];
  assign bus.y_i = pipe[L-1][0];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Expected {a0,b0,a1,b1,sel1,sel2} for every vector of a run.
  task automatic push_run(input int num, input bit inj);
    logic [15:0] v;
    logic [3:0]  a;
    v = SEED;
    for (int i = 0; i < num; i++) begin
      a = v[3:0];
      exp_q.push_back({a, v[7:4], (i == 0 && inj) ? ~a : a, v[7:4], v[9:8], v[9:8]});
      v = model_step(v);
    end
  endtask

  // Each DRIVE cycle pops one expected vector and compares the operand bus.
  always @(negedge clk) begin
    if (rst_n && state_o == S_DRIVE) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_drive", 32'(state_o), 32'(S_IDLE));
      end else begin
        chk("operands", {12'h0, bus.a0_o, bus.b0_o, bus.a1_o, bus.b1_o, bus.sel1_o, bus.sel2_o},
            {12'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int num, input bit inj);
    @(negedge clk);
    num_vec_i = 16'(num);
    inject_i  = inj;
    start_i   = 1'b1;
    @(posedge clk);
  endtask

  // Waits for done_o, counting cycles from the start-accept edge.
  task automatic wait_done(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      start_i = 1'b0;
      if (done_o) break;
      cycles++;
      if (cycles > 5000) begin
        chk("done_timeout", 32'(done_o), 32'd1);
        break;
      end
    end
  endtask

  task automatic run(input int num, input bit inj, output int cycles);
    push_run(num, inj);
    pulse_start(num, inj);
    wait_done(cycles);
  endtask

  // ---------------- table ----------------
  typedef struct {
    int num;
    bit inj;
    bit fy;
    int exp_err;
    bit exp_vld;
    int exp_idx;
  } vec_t;

  vec_t tbl[8];
  int   cyc;
  logic [19:0] ops_before;

  initial begin
    tbl[0] = '{2,   1'b0, 1'b0, 0,   1'b0, 0};
    tbl[1] = '{4,   1'b1, 1'b0, 1,   1'b1, 0};
    tbl[2] = '{0,   1'b0, 1'b0, 0,   1'b0, 0};
    tbl[3] = '{300, 1'b0, 1'b1, 255, 1'b1, 0};
    tbl[4] = '{1,   1'b1, 1'b0, 1,   1'b1, 0};
    tbl[5] = '{5,   1'b0, 1'b0, 0,   1'b0, 0};
    tbl[6] = '{7,   1'b1, 1'b1, 7,   1'b1, 0};
    tbl[7] = '{int'($urandom_range(3, 20)), 1'b0, 1'b0, 0, 1'b0, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_cnt_o), 0);
    chk("rst_ops", {12'h0, bus.a0_o, bus.b0_o, bus.a1_o, bus.b1_o, bus.sel1_o, bus.sel2_o}, 0);
    chk("rst_lfsr", 32'(lfsr_o), 32'(SEED));
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-run aborts with every output cleared at once.
    push_run(10, 1'b1);
    pulse_start(10, 1'b1);
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrun_busy_before", 32'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_done", 32'(done_o), 0);
    chk("abort_stats", {err_cnt_o, first_err_vld_o, first_err_idx_o}, 0);
    chk("abort_ops", {12'h0, bus.a0_o, bus.b0_o, bus.a1_o, bus.b1_o, bus.sel1_o, bus.sel2_o}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Clean two-vector run after the abort; first vector checked by hand too.
    push_run(2, 1'b0);
    pulse_start(2, 1'b0);
    #1;
    chk("v0_a", 32'(bus.a0_o), 32'h1);
    chk("v0_b", 32'(bus.b0_o), 32'hE);
    chk("v0_sel", 32'(bus.sel1_o), 32'h0);
    wait_done(cyc);
    chk("post_abort_cycles", cyc, 2 * (L + 2));
    chk("post_abort_err", 32'(err_cnt_o), 0);
    chk("v1_ops", {bus.a0_o, bus.b0_o, bus.sel1_o}, {4'h0, 4'h7, 2'b10});

    // Table of runs.
    for (int i = 0; i < 8; i++) begin
      force_y    = tbl[i].fy;
      ops_before = {bus.a0_o, bus.b0_o, bus.a1_o, bus.b1_o, bus.sel1_o, bus.sel2_o};
      run(tbl[i].num, tbl[i].inj, cyc);
      chk($sformatf("t%0d_cycles", i), cyc, tbl[i].num * (L + 2));
      chk($sformatf("t%0d_err", i), 32'(err_cnt_o), 32'(tbl[i].exp_err));
      chk($sformatf("t%0d_vld", i), 32'(first_err_vld_o), 32'(tbl[i].exp_vld));
      chk($sformatf("t%0d_idx", i), 32'(first_err_idx_o), 32'(tbl[i].exp_idx));
      chk($sformatf("t%0d_busy", i), 32'(busy_o), 0);
      chk($sformatf("t%0d_queue", i), exp_q.size(), 0);
      if (tbl[i].num == 0)
        chk($sformatf("t%0d_ops_hold", i),
            {12'h0, bus.a0_o, bus.b0_o, bus.a1_o, bus.b1_o, bus.sel1_o, bus.sel2_o},
            {12'h0, ops_before});
      force_y = 1'b0;
    end

    // Error on a later vector: force y only after vector 0 has been checked.
    push_run(4, 1'b0);
    pulse_start(4, 1'b0);
    @(negedge clk);
    start_i = 1'b0;
    repeat (L + 2) @(negedge clk);
    force_y = 1'b1;
    wait_done(cyc);
    force_y = 1'b0;
    chk("late_err_cnt", 32'(err_cnt_o), 3);
    chk("late_err_idx", 32'(first_err_idx_o), 1);

    // Start pulsed during WAIT is ignored; restart reproduces the sequence.
    push_run(3, 1'b0);
    pulse_start(3, 1'b0);
    begin
      int guard;
      guard = 0;
      while (state_o != S_WAIT && guard < 20) begin
        @(negedge clk);
        start_i = 1'b0;
        guard++;
      end
      chk("reach_wait", 32'(state_o), 32'(S_WAIT));
    end
    num_vec_i = 16'd50;
    inject_i  = 1'b1;
    start_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    begin
      int more;
      wait_done(more);
    end
    chk("busy_start_err", 32'(err_cnt_o), 0);
    chk("busy_start_vld", 32'(first_err_vld_o), 0);
    chk("busy_start_queue", exp_q.size(), 0);
    run(3, 1'b0, cyc);
    chk("restart_cycles", cyc, 3 * (L + 2));
    chk("restart_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
